cordic_vectoring: RTL and testbench

CORDIC_VECTORING -- requirements
Module: cordic_vectoring

---
 rtl/cordic_vectoring.sv | 174 +++++++++++++++++
 tb/tb_cordic_vectoring.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring.sv
// Iterative CORDIC in vectoring mode: converts a Q2.29 (x, y) pair into a
// Q2.29 angle atan2(y, x) and a gain-compensated Q2.29 magnitude.
// One micro-rotation per clock; the datapath runs in Q5.29 to absorb the CORDIC gain.
module cordic_vectoring #(
  parameter int unsigned N_ITER = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] x_in,
  input  logic signed [31:0] y_in,
  input  logic               input_valid,
  output logic               ready,
  output logic signed [31:0] angle_out,
  output logic signed [31:0] magnitude,
  output logic               output_valid
);

  // round(atan(2^-i) * 2^29)
  localparam logic [31:0] AtanTable [32] = '{
    32'd421657428, 32'd248918915, 32'd131521918, 32'd66762579,
    32'd33510843,  32'd16771758,  32'd8387925,   32'd4194219,
    32'd2097141,   32'd1048575,   32'd524288,    32'd262144,
    32'd131072,    32'd65536,     32'd32768,     32'd16384,
    32'd8192,      32'd4096,      32'd2048,      32'd1024,
    32'd512,       32'd256,       32'd128,       32'd64,
    32'd32,        32'd16,        32'd8,         32'd4,
    32'd2,         32'd1,         32'd0,         32'd0
  };

  localparam logic signed [34:0] HalfPi  = 35'sd843314857;
  localparam logic signed [34:0] PiQ     = 35'sd1686629713;
  localparam logic signed [31:0] PiOut   = 32'sd1686629713;
  // round(0.6072529350088813 * 2^31), inverse CORDIC gain
  localparam logic signed [66:0] InvGain = 67'sd1304065748;

  typedef enum logic [1:0] {StIdle, StPre, StIter, StScale} state_e;

  state_e             state_q, state_d;
  logic [4:0]         iter_q, iter_d;
  logic signed [34:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic               zero_q, zero_d;
  logic signed [31:0] angle_q, angle_d, mag_q, mag_d;
  logic               valid_q, valid_d;

  logic               last_iter;
  logic signed [34:0] x_sh, y_sh, atan_i;
  logic signed [66:0] x_ext, prod;
  logic signed [35:0] prod_sh;
  logic signed [31:0] mag_sat;

  assign last_iter = (iter_q == 5'(N_ITER - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (input_valid) state_d = StPre;
      StPre:   state_d = StIter;
      StIter:  if (last_iter) state_d = StScale;
      StScale: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready = (state_q == StIdle);
  end

  // Shifted operands, table lookup and gain-compensated saturated magnitude
  always_comb begin
    x_sh    = x_q >>> iter_q;
    y_sh    = y_q >>> iter_q;
    atan_i  = {3'b000, AtanTable[iter_q]};
    x_ext   = {{32{x_q[34]}}, x_q};
    prod    = x_ext * InvGain;
    prod_sh = 36'(prod >>> 31);
    if (prod_sh > 36'sd2147483647) mag_sat = 32'sh7FFF_FFFF;
    else                           mag_sat = prod_sh[31:0];
  end

  // Datapath next-state: capture, quadrant fold, micro-rotations, scaling
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    iter_d  = iter_q;
    zero_d  = zero_q;
    angle_d = angle_q;
    mag_d   = mag_q;
    valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (input_valid) begin
          x_d    = {{3{x_in[31]}}, x_in};
          y_d    = {{3{y_in[31]}}, y_in};
          z_d    = '0;
          iter_d = '0;
          // (0,0) would otherwise collect the full atan sum as its angle
          zero_d = (x_in == 32'sd0) && (y_in == 32'sd0);
        end
      end
      StPre: begin
        // Fold the left half-plane into the right so the rotations converge
        if (x_q[34] && !y_q[34]) begin
          x_d = y_q;
          y_d = -x_q;
          z_d = HalfPi;
        end else if (x_q[34]) begin
          x_d = -y_q;
          y_d = x_q;
          z_d = -HalfPi;
        end
        iter_d = '0;
      end
      StIter: begin
        if (!y_q[34]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_i;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_i;
        end
        iter_d = last_iter ? 5'd0 : iter_q + 5'd1;
      end
      StScale: begin
        valid_d = 1'b1;
        mag_d   = mag_sat;
        // Keep the result inside (-pi, pi] despite residual rotation error
        if (zero_q)            angle_d = '0;
        else if (z_q > PiQ)    angle_d = PiOut;
        else if (z_q <= -PiQ)  angle_d = -PiOut + 32'sd1;
        else                   angle_d = z_q[31:0];
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      zero_q  <= 1'b0;
      angle_q <= '0;
      mag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      iter_q  <= iter_d;
      zero_q  <= zero_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
      valid_q <= valid_d;
    end
  end

  assign angle_out    = angle_q;
  assign magnitude    = mag_q;
  assign output_valid = valid_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Self-checking bench for cordic_vectoring: requests push real-valued atan2/hypot
// expectations into a queue, a monitor pops and compares on every output_valid.
module tb_cordic_vectoring;

  localparam int  NIter = 32;
  localparam real Scale = 536870912.0;
  localparam real Pi    = 3.14159265358979323846;
  localparam real Tol   = 64.0;

  logic        clk;
  logic        rst;
  logic        input_valid;
  logic        ready;
  logic        output_valid;
  logic [31:0] x_in;
  logic [31:0] y_in;
  logic [31:0] angle_out;
  logic [31:0] magnitude;

  int  n_tests = 0;
  int  n_fail  = 0;
  real exp_ang_q[$];
  real exp_mag_q[$];

  logic [31:0] dir_x [10] = '{32'h2000_0000, 32'h2000_0000, 32'h0000_0000, 32'hE000_0000,
                              32'hE000_0000, 32'h7CCC_CCCC, 32'h0000_0000, 32'h0000_0000,
                              32'hE000_0000, 32'h2000_0000};
  logic [31:0] dir_y [10] = '{32'h0000_0000, 32'h2000_0000, 32'h2000_0000, 32'h0000_0000,
                              32'hE000_0000, 32'h7CCC_CCCC, 32'h0000_0000, 32'hE000_0000,
                              32'h2000_0000, 32'hE000_0000};

  cordic_vectoring #(.N_ITER(NIter)) dut (
    .clk         (clk),
    .rst         (rst),
    .x_in        (x_in),
    .y_in        (y_in),
    .input_valid (input_valid),
    .ready       (ready),
    .angle_out   (angle_out),
    .magnitude   (magnitude),
    .output_valid(output_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact atan2 and hypot in Q2.29 LSBs, magnitude clipped at 2^31-1
  function automatic void push_expected(input logic [31:0] x, input logic [31:0] y);
    real xr, yr, a, m;
    xr = $itor($signed(x));
    yr = $itor($signed(y));
    if (x == 32'd0 && y == 32'd0) a = 0.0;
    else                          a = $atan2(yr, xr) * Scale;
    m = $sqrt(xr * xr + yr * yr);
    if (m > 2147483647.0) m = 2147483647.0;
    exp_ang_q.push_back(a);
    exp_mag_q.push_back(m);
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Count edges until output_valid is seen (bounded)
  task automatic wait_output(output int cnt);
    cnt = 0;
    while (1) begin
      @(posedge clk);
      #1;
      cnt++;
      if (output_valid || cnt >= 200) break;
    end
  endtask

  task automatic run_vec(input logic [31:0] x, input logic [31:0] y);
    int lat;
    check_eq("ready_before_req", {31'd0, ready}, 32'd1);
    push_expected(x, y);
    x_in        = x;
    y_in        = y;
    input_valid = 1'b1;
    @(posedge clk);
    #1;
    input_valid = 1'b0;
    x_in        = $urandom;
    y_in        = $urandom;
    wait_output(lat);
    check_eq("latency", lat, NIter + 2);
  endtask

  // Monitor / scoreboard
  initial begin
    real ea, em, da, dm;
    forever begin
      @(negedge clk);
      if (rst && output_valid) begin
        n_tests++;
        if (exp_ang_q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_output: got output_valid=1 angle=%h mag=%h, expected no output",
                   angle_out, magnitude);
        end else begin
          ea = exp_ang_q.pop_front();
          em = exp_mag_q.pop_front();
          da = $itor($signed(angle_out)) - ea;
          if (da > Pi * Scale)       da = da - 2.0 * Pi * Scale;
          else if (da < -Pi * Scale) da = da + 2.0 * Pi * Scale;
          if (da > Tol || da < -Tol) begin
            n_fail++;
            $display("FAIL angle: got %h, expected %0.1f LSB (+-64)", angle_out, ea);
          end
          n_tests++;
          dm = $itor($signed(magnitude)) - em;
          if (dm > Tol || dm < -Tol) begin
            n_fail++;
            $display("FAIL magnitude: got %h, expected %0.1f LSB (+-64)", magnitude, em);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    int lat;
    rst         = 1'b0;
    input_valid = 1'b0;
    x_in        = '0;
    y_in        = '0;
    #12;
    check_eq("reset_angle", angle_out, 32'd0);
    check_eq("reset_mag", magnitude, 32'd0);
    check_eq("reset_ready", {31'd0, ready}, 32'd1);
    check_eq("reset_valid", {31'd0, output_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed corners, issued back-to-back at the maximum rate
    for (int k = 0; k < 10; k++) run_vec(dir_x[k], dir_y[k]);

    // Random vectors with |v| >= 1.0 so angle resolution stays within tolerance
    for (int k = 0; k < 20; k++) begin
      int  xi, yi;
      real r2;
      do begin
        xi = $signed($urandom) >>> 1;
        yi = $signed($urandom) >>> 1;
        r2 = $itor(xi) * $itor(xi) + $itor(yi) * $itor(yi);
      end while (r2 < 288230376151711744.0);
      run_vec(xi, yi);
    end

    // A request while busy is dropped; only the first result appears
    push_expected(32'h2000_0000, 32'h1000_0000);
    x_in        = 32'h2000_0000;
    y_in        = 32'h1000_0000;
    input_valid = 1'b1;
    @(posedge clk);
    #1;
    input_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    x_in        = 32'hE000_0000;
    y_in        = 32'h0000_0000;
    input_valid = 1'b1;
    check_eq("ready_busy", {31'd0, ready}, 32'd0);
    @(posedge clk);
    #1;
    input_valid = 1'b0;
    wait_output(lat);
    check_eq("busy_latency", 5 + lat, NIter + 2);
    repeat (NIter + 6) @(posedge clk);
    #1;

    // Asynchronous reset mid-conversion abandons it
    push_expected(32'h1000_0000, 32'hE800_0000);
    x_in        = 32'h1000_0000;
    y_in        = 32'hE800_0000;
    input_valid = 1'b1;
    @(posedge clk);
    #1;
    input_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_eq("midreset_angle", angle_out, 32'd0);
    check_eq("midreset_mag", magnitude, 32'd0);
    check_eq("midreset_ready", {31'd0, ready}, 32'd1);
    check_eq("midreset_valid", {31'd0, output_valid}, 32'd0);
    void'(exp_ang_q.pop_back());
    void'(exp_mag_q.pop_back());
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (NIter + 6) @(posedge clk);
    #1;
    run_vec(32'hD000_0000, 32'h1800_0000);

    repeat (5) @(posedge clk);
    #1;
    check_eq("pending_results", exp_ang_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
